control_unit: RTL and testbench

Multi-cycle fetch/decode/execute sequencer that sits directly upstream of the ARM datapath and drives its register, memory and mux enables. It fetches each instruction through MAR/RAM/IR, evaluates the ARM condition field against the status flags, then sequences data-processing, load/store and branch execution. It includes a memory-wait watchdog, a sticky fault state and a retired-instruction counter.

---
 rtl/arm_ctrl_pkg.sv | 45 ++++
 rtl/cond_check.sv | 35 +++
 rtl/control_unit.sv | 153 +++++++++++++++
 tb/tb_control_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the ARM control sequencer: state encoding, condition codes,
// instruction classes and memory word-select values.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    FETCH_ADDR = 4'd1,
    FETCH_WAIT = 4'd2,
    FETCH_LOAD = 4'd3,
    DECODE     = 4'd4,
    EXEC_DP    = 4'd5,
    MEM_ADDR   = 4'd6,
    MDR_LOAD   = 4'd7,
    MEM_WAIT   = 4'd8,
    MEM_WB     = 4'd9,
    BRANCH     = 4'd10,
    PC_INC     = 4'd11,
    FAULT      = 4'd12
  } ctrlState_t;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] CLASS_DP = 2'b00;
  localparam logic [1:0] CLASS_LS = 2'b01;
  localparam logic [1:0] CLASS_BR = 2'b10;

  localparam logic [1:0] WSEL_BYTE = 2'b00;
  localparam logic [1:0] WSEL_WORD = 2'b10;

endpackage

// File: rtl/cond_check.sv
// ARM condition-field evaluator against the {N,Z,C,V} status flags.
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the ARM datapath enables,
// with a memory-wait watchdog, sticky fault state and retired-instruction counter.
module control_unit
  import arm_ctrl_pkg::*;
#(
  parameter int MFC_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] ir,
  input  logic [3:0]  flags,
  input  logic        mfc,
  output logic        mar_en,
  output logic        mar_src,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [1:0]  word_sel,
  output logic        ir_en,
  output logic        mdr_en,
  output logic        mdr_sel,
  output logic        reg_en,
  output logic        flag_en,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        fault,
  output logic [31:0] instr_count,
  output logic [3:0]  state
);

  localparam int CntW = $clog2(MFC_TIMEOUT);

  ctrlState_t       stateQ, nextState;
  logic [CntW-1:0]  waitCnt;
  logic [31:0]      instrCount;
  logic             condPass;
  logic             inWait;
  logic             timeout;
  logic             unusedIrBits;

  assign unusedIrBits = ^{ir[25:23], ir[21], ir[19:0]};

  cond_check uCondCheck (
    .cond  (ir[31:28]),
    .flags (flags),
    .pass  (condPass)
  );

  assign inWait  = (stateQ == FETCH_WAIT) || (stateQ == MEM_WAIT);
  assign timeout = (waitCnt == CntW'(MFC_TIMEOUT - 1));

  // State register, watchdog and retirement counter
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      stateQ     <= IDLE;
      waitCnt    <= '0;
      instrCount <= '0;
    end else begin
      stateQ <= nextState;
      // Wait states are never entered back-to-back, so clearing outside them
      // guarantees a zero count on every entry.
      if (!inWait)
        waitCnt <= '0;
      else if (!mfc)
        waitCnt <= waitCnt + CntW'(1);
      if ((stateQ == PC_INC) || (stateQ == BRANCH))
        instrCount <= instrCount + 32'd1;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    nextState = stateQ;
    mar_en    = 1'b0;
    mar_src   = 1'b0;
    ram_en    = 1'b0;
    ram_rw    = 1'b0;
    word_sel  = 2'b00;
    ir_en     = 1'b0;
    mdr_en    = 1'b0;
    mdr_sel   = 1'b0;
    reg_en    = 1'b0;
    flag_en   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    fault     = 1'b0;
    case (stateQ)
      IDLE: nextState = FETCH_ADDR;
      FETCH_ADDR: begin
        mar_en    = 1'b1;
        nextState = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        ram_en   = 1'b1;
        word_sel = WSEL_WORD;
        if (mfc)          nextState = FETCH_LOAD;
        else if (timeout) nextState = FAULT;
      end
      FETCH_LOAD: begin
        ir_en     = 1'b1;
        mdr_sel   = 1'b1;
        nextState = DECODE;
      end
      DECODE: begin
        if (!condPass)                 nextState = PC_INC;
        else if (ir[27:26] == CLASS_DP) nextState = EXEC_DP;
        else if (ir[27:26] == CLASS_LS) nextState = MEM_ADDR;
        else if (ir[27:26] == CLASS_BR) nextState = BRANCH;
        else                            nextState = PC_INC;
      end
      EXEC_DP: begin
        reg_en    = 1'b1;
        flag_en   = ir[20];
        nextState = PC_INC;
      end
      MEM_ADDR: begin
        mar_en    = 1'b1;
        mar_src   = 1'b1;
        nextState = ir[20] ? MEM_WAIT : MDR_LOAD;
      end
      MDR_LOAD: begin
        mdr_en    = 1'b1;
        nextState = MEM_WAIT;
      end
      MEM_WAIT: begin
        ram_en   = 1'b1;
        ram_rw   = ~ir[20];
        word_sel = ir[22] ? WSEL_BYTE : WSEL_WORD;
        if (mfc)          nextState = ir[20] ? MEM_WB : PC_INC;
        else if (timeout) nextState = FAULT;
      end
      MEM_WB: begin
        mdr_en    = 1'b1;
        mdr_sel   = 1'b1;
        reg_en    = 1'b1;
        nextState = PC_INC;
      end
      BRANCH: begin
        pc_load   = 1'b1;
        nextState = FETCH_ADDR;
      end
      PC_INC: begin
        pc_inc    = 1'b1;
        nextState = FETCH_ADDR;
      end
      FAULT: fault = 1'b1;
      default: nextState = IDLE;
    endcase
  end

  assign instr_count = instrCount;
  assign state       = stateQ;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: walks each instruction class cycle by cycle
// and checks state, every enable and the retired-instruction count.
module tb_control_unit;

  localparam logic [3:0] S_IDLE = 4'd0,  S_FA = 4'd1,  S_FW = 4'd2,  S_FL = 4'd3;
  localparam logic [3:0] S_DEC  = 4'd4,  S_DP = 4'd5,  S_MA = 4'd6,  S_ML = 4'd7;
  localparam logic [3:0] S_MW   = 4'd8,  S_WB = 4'd9,  S_BR = 4'd10, S_PI = 4'd11;
  localparam logic [3:0] S_FLT  = 4'd12;

  // Output vector: {mar_en,mar_src,ram_en,ram_rw,word_sel[1:0],ir_en,mdr_en,
  //                 mdr_sel,reg_en,flag_en,pc_inc,pc_load,fault}
  localparam logic [13:0] O_NONE = 14'h0000;
  localparam logic [13:0] O_FA   = 14'h2000;
  localparam logic [13:0] O_FW   = 14'h0A00;
  localparam logic [13:0] O_FL   = 14'h00A0;
  localparam logic [13:0] O_DPS  = 14'h0018;
  localparam logic [13:0] O_DP   = 14'h0010;
  localparam logic [13:0] O_MA   = 14'h3000;
  localparam logic [13:0] O_ML   = 14'h0040;
  localparam logic [13:0] O_MWLB = 14'h0800;
  localparam logic [13:0] O_MWSW = 14'h0E00;
  localparam logic [13:0] O_WB   = 14'h0070;
  localparam logic [13:0] O_BR   = 14'h0002;
  localparam logic [13:0] O_PI   = 14'h0004;
  localparam logic [13:0] O_FLT  = 14'h0001;

  logic        Clk, Clr, mfc;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic        mar_en, mar_src, ram_en, ram_rw, ir_en, mdr_en, mdr_sel;
  logic        reg_en, flag_en, pc_inc, pc_load, fault;
  logic [1:0]  word_sel;
  logic [31:0] instr_count;
  logic [3:0]  state;
  logic [13:0] outs;

  int nChecks = 0;
  int nFails  = 0;

  control_unit #(.MFC_TIMEOUT(16)) dut (
    .Clk(Clk), .Clr(Clr), .ir(ir), .flags(flags), .mfc(mfc),
    .mar_en(mar_en), .mar_src(mar_src), .ram_en(ram_en), .ram_rw(ram_rw),
    .word_sel(word_sel), .ir_en(ir_en), .mdr_en(mdr_en), .mdr_sel(mdr_sel),
    .reg_en(reg_en), .flag_en(flag_en), .pc_inc(pc_inc), .pc_load(pc_load),
    .fault(fault), .instr_count(instr_count), .state(state)
  );

  assign outs = {mar_en, mar_src, ram_en, ram_rw, word_sel, ir_en, mdr_en,
                 mdr_sel, reg_en, flag_en, pc_inc, pc_load, fault};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] expState, input logic [13:0] expOuts);
    @(posedge Clk);
    #1;
    checkVal({tag, "/state"}, {28'd0, state}, {28'd0, expState});
    checkVal({tag, "/outs"}, {18'd0, outs}, {18'd0, expOuts});
  endtask

  // Fetch with memory answering in the first wait cycle, ending in DECODE.
  task automatic fetch(input string tag);
    mfc = 1'b1;
    step({tag, ".fw"}, S_FW, O_FW);
    step({tag, ".fl"}, S_FL, O_FL);
    step({tag, ".dec"}, S_DEC, O_NONE);
  endtask

  initial begin
    Clr = 1'b0; mfc = 1'b0; ir = 32'd0; flags = 4'd0;
    step("rst", S_IDLE, O_NONE);
    step("rst2", S_IDLE, O_NONE);
    checkVal("rst.cnt", instr_count, 32'd0);
    Clr = 1'b1;
    step("start", S_FA, O_FA);

    // ADDS, cond AL: 6 cycles, retires once
    ir = 32'hE090_0000;
    fetch("adds");
    step("adds.ex", S_DP, O_DPS);
    step("adds.pi", S_PI, O_PI);
    checkVal("adds.cnt0", instr_count, 32'd0);
    step("adds.next", S_FA, O_FA);
    checkVal("adds.cnt1", instr_count, 32'd1);

    // BEQ with Z=0: condition fails, no pc_load
    ir = 32'h0A00_0000; flags = 4'b0000;
    fetch("beq0");
    step("beq0.pi", S_PI, O_PI);
    step("beq0.next", S_FA, O_FA);
    checkVal("beq0.cnt", instr_count, 32'd2);

    // BEQ with Z=1: taken, no pc_inc
    flags = 4'b0100;
    fetch("beq1");
    step("beq1.br", S_BR, O_BR);
    step("beq1.next", S_FA, O_FA);
    checkVal("beq1.cnt", instr_count, 32'd3);

    // ADDGT (no S) with N=V=1, Z=0: passes, flag_en stays low
    ir = 32'hC080_0000; flags = 4'b1001;
    fetch("addgt");
    step("addgt.ex", S_DP, O_DP);
    step("addgt.pi", S_PI, O_PI);
    step("addgt.next", S_FA, O_FA);
    checkVal("addgt.cnt", instr_count, 32'd4);

    // Condition 1111 never passes
    ir = 32'hF090_0000; flags = 4'b0100;
    fetch("nv");
    step("nv.pi", S_PI, O_PI);
    step("nv.next", S_FA, O_FA);
    checkVal("nv.cnt", instr_count, 32'd5);

    // Class 11 is a no-op
    ir = 32'hEC00_0000;
    fetch("cls3");
    step("cls3.pi", S_PI, O_PI);
    step("cls3.next", S_FA, O_FA);
    checkVal("cls3.cnt", instr_count, 32'd6);

    // LDRB with mfc delayed 3 cycles: MEM_WAIT lasts 4 cycles
    ir = 32'hE450_0000;
    fetch("ldrb");
    step("ldrb.ma", S_MA, O_MA);
    mfc = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin
        step($sformatf("ldrb.mw%0d", i), S_MW, O_MWLB);
        mfc = 1'b1;
      end else begin
        step($sformatf("ldrb.mw%0d", i), S_MW, O_MWLB);
      end
    end
    step("ldrb.wb", S_WB, O_WB);
    step("ldrb.pi", S_PI, O_PI);
    step("ldrb.next", S_FA, O_FA);
    checkVal("ldrb.cnt", instr_count, 32'd7);

    // STR word: MDR_LOAD then a write wait, no register write
    ir = 32'hE400_0000;
    fetch("str");
    step("str.ma", S_MA, O_MA);
    step("str.ml", S_ML, O_ML);
    step("str.mw", S_MW, O_MWSW);
    step("str.pi", S_PI, O_PI);
    step("str.next", S_FA, O_FA);
    checkVal("str.cnt", instr_count, 32'd8);

    // Reset in the middle of a fetch wait
    mfc = 1'b0;
    step("rstmid.fw", S_FW, O_FW);
    Clr = 1'b0;
    step("rstmid.idle", S_IDLE, O_NONE);
    checkVal("rstmid.cnt", instr_count, 32'd0);
    Clr = 1'b1;
    step("rstmid.fa", S_FA, O_FA);

    // mfc never returns: 16 wait cycles, then sticky FAULT
    mfc = 1'b0;
    for (int i = 1; i <= 16; i++)
      step($sformatf("to.fw%0d", i), S_FW, O_FW);
    step("to.fault", S_FLT, O_FLT);
    mfc = 1'b1;
    step("to.hold1", S_FLT, O_FLT);
    step("to.hold2", S_FLT, O_FLT);
    checkVal("to.cnt", instr_count, 32'd0);
    Clr = 1'b0;
    step("to.clr", S_IDLE, O_NONE);
    Clr = 1'b1;
    step("to.fa", S_FA, O_FA);

    // mfc arrives in the 16th wait cycle: completes instead of faulting
    mfc = 1'b0;
    for (int i = 1; i <= 16; i++)
      step($sformatf("late.fw%0d", i), S_FW, O_FW);
    mfc = 1'b1;
    step("late.fl", S_FL, O_FL);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
